tone_sched: RTL

TONE_SCHED -- requirements
Module: tone_sched

---
 rtl/tone_sched_if.sv | 28 ++
 rtl/tone_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tone_sched_if.sv
`timescale 1ns/1ps
// tone_sched_if
// Groups the tune request inputs, the note command handshake towards the tone
// generator and the status outputs of tone_sched.
//   slave  : scheduler side (receives requests and note_rdy/note_done, drives note command + status)
//   master : environment side (drives requests and tone generator responses)
interface tone_sched_if;
    logic        too_fast;
    logic        batt_low;
    logic        en_steer;
    logic        note_rdy;
    logic        note_done;
    logic        note_vld;
    logic [14:0] note_period;
    logic [24:0] note_dur;
    logic [1:0]  tune_id;
    logic        busy;

    modport slave (
        input  too_fast, batt_low, en_steer, note_rdy, note_done,
        output note_vld, note_period, note_dur, tune_id, busy
    );

    modport master (
        output too_fast, batt_low, en_steer, note_rdy, note_done,
        input  note_vld, note_period, note_dur, tune_id, busy
    );
endinterface

// File: rtl/tone_sched.sv
`timescale 1ns/1ps
// tone_sched
// Plays short alert tunes by issuing one note at a time to a tone generator.
// Ports:
//   clk  - system clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - tone_sched_if.slave: requests (too_fast, batt_low, en_steer),
//          tone generator handshake (note_rdy, note_done, note_vld,
//          note_period, note_dur) and status (tune_id, busy)
//
// state | meaning
// IDLE  | no tune active, waiting for a request
// ISSUE | note command presented, waiting for note_rdy
// PLAY  | note accepted, waiting for note_done
module tone_sched #(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    tone_sched_if.slave  bus
);

    localparam int unsigned INTERVAL  = FAST_SIM ? 5000 : 150000000;
    localparam int unsigned DUR_SHIFT = FAST_SIM ? 9 : 0;

    localparam logic [27:0] RPT_RELOAD = 28'(INTERVAL - 1);

    localparam logic [24:0] DUR_S = 25'(32'd4194304  >> DUR_SHIFT);
    localparam logic [24:0] DUR_N = 25'(32'd8388608  >> DUR_SHIFT);
    localparam logic [24:0] DUR_L = 25'(32'd12582912 >> DUR_SHIFT);
    localparam logic [24:0] DUR_X = 25'(32'd16777216 >> DUR_SHIFT);

    localparam logic [1:0] P_G6 = 2'd0, P_C7 = 2'd1, P_E7 = 2'd2, P_G7 = 2'd3;
    localparam logic [1:0] L_S  = 2'd0, L_N  = 2'd1, L_L  = 2'd2, L_X  = 2'd3;

    localparam logic [1:0] TUNE_NONE = 2'd0, TUNE_FAST = 2'd1,
                           TUNE_BATT = 2'd2, TUNE_STEER = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, PLAY} state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  tune_q, tune_d;
    logic [27:0] rpt_cnt_q, rpt_cnt_d;
    logic        rpt_pend_q, rpt_pend_d;
    logic        gated_start;
    logic [3:0]  note_code;
    logic [2:0]  last_idx;
    logic [14:0] period;
    logic [24:0] dur;

    // Note code is {pitch, length}; batt_low is the en_steer tune reversed.
    function automatic logic [3:0] tune_note(input logic [1:0] tune, input logic [2:0] idx);
        logic [3:0] code;
        code = {P_G6, L_N};
        case (tune)
            TUNE_FAST: begin
                case (idx)
                    3'd0:    code = {P_G6, L_N};
                    3'd1:    code = {P_C7, L_N};
                    default: code = {P_E7, L_N};
                endcase
            end
            TUNE_BATT: begin
                case (idx)
                    3'd0:    code = {P_G7, L_X};
                    3'd1:    code = {P_E7, L_S};
                    3'd2:    code = {P_G7, L_L};
                    3'd3:    code = {P_E7, L_N};
                    3'd4:    code = {P_C7, L_N};
                    default: code = {P_G6, L_N};
                endcase
            end
            default: begin
                case (idx)
                    3'd0:    code = {P_G6, L_N};
                    3'd1:    code = {P_C7, L_N};
                    3'd2:    code = {P_E7, L_N};
                    3'd3:    code = {P_G7, L_L};
                    3'd4:    code = {P_E7, L_S};
                    default: code = {P_G7, L_X};
                endcase
            end
        endcase
        return code;
    endfunction

    always_comb begin
        note_code = tune_note(tune_q, idx_q);
        last_idx  = (tune_q == TUNE_FAST) ? 3'd2 : 3'd5;
        case (note_code[3:2])
            P_G6:    period = 15'd31888;
            P_C7:    period = 15'd23890;
            P_E7:    period = 15'd18961;
            default: period = 15'd15944;
        endcase
        case (note_code[1:0])
            L_S:     dur = DUR_S;
            L_N:     dur = DUR_N;
            L_L:     dur = DUR_L;
            default: dur = DUR_X;
        endcase
    end

    // Note fields are only driven while a command is offered, so they read
    // zero in reset and whenever no note is pending.
    assign bus.note_vld    = (state_q == ISSUE);
    assign bus.note_period = (state_q == ISSUE) ? period : 15'd0;
    assign bus.note_dur    = (state_q == ISSUE) ? dur : 25'd0;
    assign bus.tune_id     = tune_q;
    assign bus.busy        = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tune_d      = tune_q;
        gated_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.too_fast) begin
                    tune_d  = TUNE_FAST;
                    idx_d   = 3'd0;
                    state_d = ISSUE;
                end else if (bus.batt_low && rpt_pend_q) begin
                    tune_d      = TUNE_BATT;
                    idx_d       = 3'd0;
                    state_d     = ISSUE;
                    gated_start = 1'b1;
                end else if (bus.en_steer && rpt_pend_q) begin
                    tune_d      = TUNE_STEER;
                    idx_d       = 3'd0;
                    state_d     = ISSUE;
                    gated_start = 1'b1;
                end
            end
            ISSUE: begin
                if (bus.note_rdy) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (bus.note_done) begin
                    if (bus.too_fast && (tune_q != TUNE_FAST)) begin
                        tune_d  = TUNE_FAST;
                        idx_d   = 3'd0;
                        state_d = ISSUE;
                    end else if (idx_q == last_idx) begin
                        tune_d  = TUNE_NONE;
                        idx_d   = 3'd0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running repeat timer; expiry re-arms the gated tunes and wins over
    // a start clearing rpt_pend in the same cycle.
    always_comb begin
        if (rpt_cnt_q == 28'd0) begin
            rpt_cnt_d  = RPT_RELOAD;
            rpt_pend_d = 1'b1;
        end else begin
            rpt_cnt_d  = rpt_cnt_q - 28'd1;
            rpt_pend_d = gated_start ? 1'b0 : rpt_pend_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            tune_q     <= TUNE_NONE;
            rpt_cnt_q  <= RPT_RELOAD;
            rpt_pend_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tune_q     <= tune_d;
            rpt_cnt_q  <= rpt_cnt_d;
            rpt_pend_q <= rpt_pend_d;
        end
    end

endmodule
